pc_fetch_unit: RTL

Program-counter and instruction-fetch stage directly upstream of the JALR unit. Holds the architectural PC, issues one instruction-memory request at a time, and presents the fetched instruction with its PC and PC+4 to decode/execute, where PC+4 becomes the link value for JAL/JALR. Accepts redirects from the JALR unit and the branch unit, clears the JALR target LSB, and raises a misaligned-target trap instead of fetching from a bad address.

---
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave). One request outstanding at a time.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: single-outstanding fetch, JALR/branch
// redirects with kill of in-flight responses, misaligned-target trap.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_fetch_unit_if.master         imem,
  input  logic                    redirect_jalr,
  input  logic [31:0]             jalr_target,
  input  logic                    redirect_br,
  input  logic [31:0]             br_target,
  input  logic                    stall,
  output logic                    if_valid,
  output logic [31:0]             if_instr,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_pc_plus4,
  output logic                    misaligned_trap,
  output logic [31:0]             trap_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        pending;
  logic        kill;

  // JALR wins over branch; the JALR target always has bit 0 cleared.
  function automatic logic [31:0] redirect_target(
    input logic        is_jalr,
    input logic [31:0] jt,
    input logic [31:0] bt
  );
    if (is_jalr) redirect_target = {jt[31:1], 1'b0};
    else         redirect_target = bt;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] t);
    is_misaligned = (t[1:0] != 2'b00);
  endfunction

  logic        redirect;
  logic [31:0] tgt;
  logic        tgt_bad;
  logic        accept;
  logic        resp;
  logic        still_out;

  assign redirect = redirect_jalr | redirect_br;
  assign tgt      = redirect_target(redirect_jalr, jalr_target, br_target);
  assign tgt_bad  = is_misaligned(tgt);

  assign imem.imem_req  = (state == FETCH) && !pending && !rst;
  assign imem.imem_addr = pc;

  assign accept    = imem.imem_req && imem.imem_ready;
  // Responses only count while a request is outstanding, so a stray rvalid
  // after reset is ignored.
  assign resp      = imem.imem_rvalid && pending;
  // A request still in flight after this edge must have its response killed.
  assign still_out = accept || (pending && !imem.imem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      pending         <= 1'b0;
      kill            <= 1'b0;
      if_valid        <= 1'b0;
      if_instr        <= 32'h0;
      if_pc           <= 32'h0;
      if_pc_plus4     <= 32'h0;
      misaligned_trap <= 1'b0;
      trap_pc         <= 32'h0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      pending  <= still_out;
      kill     <= still_out;
      if (tgt_bad) begin
        misaligned_trap <= 1'b1;
        trap_pc         <= tgt;
        state           <= TRAP;
      end else begin
        misaligned_trap <= 1'b0;
        pc              <= tgt;
        state           <= FETCH;
      end
    end else begin
      // A killed response can drain in whatever state we have moved on to.
      if (resp && kill) begin
        pending <= 1'b0;
        kill    <= 1'b0;
      end
      case (state)
        FETCH: begin
          if (accept) begin
            pending <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (resp && !kill) begin
            if_instr    <= imem.imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc + 32'd4;
            if_valid    <= 1'b1;
            pc          <= pc + 32'd4;
            pending     <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
